// File: rtl/traffic_light_controller.sv
// Fixed-time T-junction signal controller (M1, M2, MT, S heads); `define TLC_ALL_RED_EN adds all-red clearance.
// Latency: lamps are a combinational decode of the registered phase; each phase lasts its T_* in clocks.
// Backpressure: none; free-running Moore FSM with no handshake inputs.
module traffic_light_controller #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned T_MG  = 7,
    parameter int unsigned T_Y   = 2,
    parameter int unsigned T_TG  = 5,
    parameter int unsigned T_SG  = 3,
    parameter int unsigned T_AR  = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S
);

    localparam logic [2:0] S1 = 3'd0;
    localparam logic [2:0] S2 = 3'd1;
    localparam logic [2:0] S3 = 3'd2;
    localparam logic [2:0] S4 = 3'd3;
    localparam logic [2:0] S5 = 3'd4;
    localparam logic [2:0] S6 = 3'd5;
    localparam logic [2:0] AR = 3'd6;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // A zero duration behaves as one clock, so the terminal count saturates at 0.
    function automatic logic [CNT_W-1:0] last_cnt(input int unsigned t);
        return (t == 0) ? '0 : CNT_W'(t - 1);
    endfunction

    localparam logic [CNT_W-1:0] MG_LAST = last_cnt(T_MG);
    localparam logic [CNT_W-1:0] Y_LAST  = last_cnt(T_Y);
    localparam logic [CNT_W-1:0] TG_LAST = last_cnt(T_TG);
    localparam logic [CNT_W-1:0] SG_LAST = last_cnt(T_SG);
    localparam logic [CNT_W-1:0] AR_LAST = last_cnt(T_AR);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] phase_last;
    logic             state_legal;
    logic             ar_to_s5;
    logic             phase_done;

`ifdef TLC_ALL_RED_EN
    assign state_legal = (state <= AR);
`else
    assign state_legal = (state <= S6);
    assign ar_to_s5    = 1'b0;
`endif

    assign phase_done = (count == phase_last);

    always_comb begin
        phase_last = '0;
        next_state = S1;
        case (state)
            S1: begin phase_last = MG_LAST; next_state = S2; end
            S2: begin phase_last = Y_LAST;  next_state = S3; end
            S3: begin phase_last = TG_LAST; next_state = S4; end
`ifdef TLC_ALL_RED_EN
            S4: begin phase_last = Y_LAST;  next_state = AR; end
            S6: begin phase_last = Y_LAST;  next_state = AR; end
`else
            S4: begin phase_last = Y_LAST;  next_state = S5; end
            S6: begin phase_last = Y_LAST;  next_state = S1; end
`endif
            S5: begin phase_last = SG_LAST; next_state = S6; end
            AR: begin phase_last = AR_LAST; next_state = ar_to_s5 ? S5 : S1; end
            default: begin phase_last = '0; next_state = S1; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S1;
            count <= '0;
        end else if (!state_legal) begin
            state <= S1;
            count <= '0;
        end else if (phase_done) begin
            state <= next_state;
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

`ifdef TLC_ALL_RED_EN
    // Remembers whether the pending/active all-red follows S4 (then S5) or S6 (then S1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_to_s5 <= 1'b0;
        end else if (state_legal && phase_done) begin
            if (state == S4) begin
                ar_to_s5 <= 1'b1;
            end else if (state == AR) begin
                ar_to_s5 <= 1'b0;
            end
        end
    end
`endif

    // All-red phase and any illegal encoding fall through to the all-red default.
    always_comb begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
        case (state)
            S1: begin light_M1 = GRN; light_M2 = GRN; end
            S2: begin light_M1 = GRN; light_M2 = YEL; end
            S3: begin light_M1 = GRN; light_MT = GRN; end
            S4: begin light_M1 = YEL; light_MT = YEL; end
            S5: begin light_S  = GRN; end
            S6: begin light_S  = YEL; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: reference phase model feeds a scoreboard queue, checked at negedge.
// Honours TLC_ALL_RED_EN so the same bench covers both builds.
module tb_traffic_light_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [2:0] f_M1, f_M2, f_MT, f_S;
    logic [11:0] obs, fobs;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] L_S1 = 12'b001_001_100_100;
    localparam logic [11:0] L_S2 = 12'b001_010_100_100;
    localparam logic [11:0] L_S3 = 12'b001_100_001_100;
    localparam logic [11:0] L_S4 = 12'b010_100_010_100;
    localparam logic [11:0] L_S5 = 12'b100_100_100_001;
    localparam logic [11:0] L_S6 = 12'b100_100_100_010;
    localparam logic [11:0] L_AR = 12'b100_100_100_100;

`ifdef TLC_ALL_RED_EN
    localparam int PERIOD = 23;
`else
    localparam int PERIOD = 21;
`endif

    logic [11:0] lights_tbl[8];
    int          dur_tbl[8];
    int          seq_len;
    int          m_idx, m_cnt, f_idx;
    bit          fast_en = 1'b0;
    logic [11:0] exp_q[$];
    logic [11:0] fast_q[$];
    logic [11:0] hist[64];

    traffic_light_controller dut (
        .clk      (clk),
        .rst      (rst),
        .light_M1 (light_M1),
        .light_M2 (light_M2),
        .light_MT (light_MT),
        .light_S  (light_S)
    );

    traffic_light_controller #(.T_MG(1), .T_Y(1), .T_TG(1), .T_SG(1)) dut_fast (
        .clk      (clk),
        .rst      (rst),
        .light_M1 (f_M1),
        .light_M2 (f_M2),
        .light_MT (f_MT),
        .light_S  (f_S)
    );

    assign obs  = {light_M1, light_M2, light_MT, light_S};
    assign fobs = {f_M1, f_M2, f_MT, f_S};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic init_model();
`ifdef TLC_ALL_RED_EN
        lights_tbl = '{L_S1, L_S2, L_S3, L_S4, L_AR, L_S5, L_S6, L_AR};
        dur_tbl    = '{7, 2, 5, 2, 1, 3, 2, 1};
        seq_len    = 8;
`else
        lights_tbl = '{L_S1, L_S2, L_S3, L_S4, L_S5, L_S6, L_AR, L_AR};
        dur_tbl    = '{7, 2, 5, 2, 3, 2, 1, 1};
        seq_len    = 6;
`endif
        m_idx = 0;
        m_cnt = 0;
        f_idx = 0;
    endtask

    // One clock: advance the reference model at posedge, push expectations, return at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_idx = 0;
            m_cnt = 0;
            f_idx = 0;
        end else begin
            if (m_cnt == dur_tbl[m_idx] - 1) begin
                m_idx = (m_idx + 1) % seq_len;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            f_idx = (f_idx + 1) % seq_len;
        end
        exp_q.push_back(lights_tbl[m_idx]);
        if (fast_en) fast_q.push_back(lights_tbl[f_idx]);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== L_S1) begin errors++; $display("FAIL reset_async_out: got %b required %b", obs, L_S1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL reset_hold: got %b required %b", obs, e); end
            checks++;
            if (obs !== L_S1) begin errors++; $display("FAIL reset_hold_const: got %b required %b", obs, L_S1); end
        end
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL first_phases sb edge %0d: got %b required %b", i, obs, e); end
            checks++;
            if (i <= 6 && obs !== L_S1) begin
                errors++; $display("FAIL s1_len edge %0d: got %b required %b", i, obs, L_S1);
            end else if ((i == 7 || i == 8) && light_M2 !== 3'b010) begin
                errors++; $display("FAIL m2_yellow edge %0d: got %b required 010", i, light_M2);
            end else if (i == 9 && {light_M2, light_MT} !== 6'b100_001) begin
                errors++; $display("FAIL turn_green: got M2=%b MT=%b required 100/001", light_M2, light_MT);
            end
        end
    endtask

    task automatic test_free_run();
        logic [11:0] e;
        rst = 1'b1;
        tick();
        void'(exp_q.pop_front());
        rst = 1'b0;
        hist[0] = obs;
        for (int k = 1; k < 48; k++) begin
            tick();
            e = exp_q.pop_front();
            hist[k] = obs;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL free_run sb clk %0d: got %b required %b", k, obs, e); end
        end
        checks++;
        if (hist[0] !== L_S1) begin errors++; $display("FAIL free_run clk0: got %b required %b", hist[0], L_S1); end
        for (int k = 0; k + PERIOD < 48; k++) begin
            checks++;
            if (hist[k] !== hist[k + PERIOD]) begin
                errors++; $display("FAIL period clk %0d: got %b required %b", k + PERIOD, hist[k + PERIOD], hist[k]);
            end
        end
`ifndef TLC_ALL_RED_EN
        for (int k = 0; k < 42; k++) begin
            checks++;
            if ((hist[k][2:0] === 3'b001) !== ((k % 21) >= 16 && (k % 21) <= 18)) begin
                errors++; $display("FAIL side_green clk %0d: got S=%b", k, hist[k][2:0]);
            end
        end
`endif
    endtask

`ifdef TLC_ALL_RED_EN
    task automatic test_all_red();
        checks++;
        if (hist[15] !== L_S4 || hist[16] !== L_AR || hist[17] !== L_S5) begin
            errors++; $display("FAIL ar_after_s4: got %b %b %b required %b %b %b",
                               hist[15], hist[16], hist[17], L_S4, L_AR, L_S5);
        end
        checks++;
        if (hist[21] !== L_S6 || hist[22] !== L_AR || hist[23] !== L_S1) begin
            errors++; $display("FAIL ar_after_s6: got %b %b %b required %b %b %b",
                               hist[21], hist[22], hist[23], L_S6, L_AR, L_S1);
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [11:0] e;
        rst = 1'b1;
        tick();
        void'(exp_q.pop_front());
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            void'(exp_q.pop_front());
        end
        checks++;
        if (obs !== L_S5) begin errors++; $display("FAIL in_s5: got %b required %b", obs, L_S5); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== L_S1) begin errors++; $display("FAIL async_abort: got %b required %b", obs, L_S1); end
        for (int k = 0; k < 2; k++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL async_hold sb: got %b required %b", obs, e); end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL async_resume sb edge %0d: got %b required %b", k, obs, e); end
            checks++;
            if (obs !== ((k <= 6) ? L_S1 : L_S2)) begin
                errors++; $display("FAIL async_resume edge %0d: got %b required %b", k, obs, (k <= 6) ? L_S1 : L_S2);
            end
        end
    endtask

    task automatic test_invariants();
        logic [11:0] e;
        logic        main_on;
        rst = 1'b1;
        tick();
        void'(exp_q.pop_front());
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL inv sb clk %0d: got %b required %b", i, obs, e); end
            checks++;
            if (!($onehot(light_M1) && $onehot(light_M2) && $onehot(light_MT) && $onehot(light_S))) begin
                errors++; $display("FAIL inv_onehot clk %0d: got %b", i, obs);
            end
            main_on = (light_M1 !== 3'b100) || (light_M2 !== 3'b100) || (light_MT !== 3'b100);
            checks++;
            if (main_on && light_S !== 3'b100) begin
                errors++; $display("FAIL inv_side_conflict clk %0d: got %b", i, obs);
            end
            checks++;
            if (light_MT === 3'b001 && light_M2 !== 3'b100) begin
                errors++; $display("FAIL inv_turn_conflict clk %0d: got %b", i, obs);
            end
            rst = ((i % 21) == 20);
        end
        rst = 1'b0;
    endtask

    task automatic test_fast_params();
        logic [11:0] e, prev;
        fast_en = 1'b1;
        rst = 1'b1;
        tick();
        void'(exp_q.pop_front());
        void'(fast_q.pop_front());
        rst = 1'b0;
        hist[0] = fobs;
        prev = fobs;
        for (int k = 1; k <= 3 * seq_len; k++) begin
            tick();
            void'(exp_q.pop_front());
            e = fast_q.pop_front();
            hist[k] = fobs;
            checks++;
            if (fobs !== e) begin errors++; $display("FAIL fast sb clk %0d: got %b required %b", k, fobs, e); end
            checks++;
            if (fobs === prev) begin errors++; $display("FAIL fast_change clk %0d: got %b unchanged", k, fobs); end
            prev = fobs;
        end
        for (int k = 0; k < 2 * seq_len; k++) begin
            checks++;
            if (hist[k] !== hist[k + seq_len]) begin
                errors++; $display("FAIL fast_period clk %0d: got %b required %b", k + seq_len, hist[k + seq_len], hist[k]);
            end
        end
        fast_en = 1'b0;
    endtask

    initial begin
        init_model();
        test_reset();
        test_free_run();
`ifdef TLC_ALL_RED_EN
        test_all_red();
`endif
        test_async_reset();
        test_invariants();
        test_fast_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
